bus_initiator: RTL and testbench
================================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter READ_LATENCY, default 2: cycles from address-drive to BUS_DATA sample on a read, legal range 1..7.
REQ-002 Parameter NUM_IRQ, default 2: number of interrupt raise/ack pairs served.
REQ-003 CLK  input  1  sole clock; all logic is on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 CMD_VALID  input  1  host command request.
REQ-006 CMD_READY  output  1  block can accept a command.
REQ-007 CMD_WRITE  input  1  1 = bus write, 0 = bus read.
REQ-008 CMD_ADDR  input  8  target bus address.
REQ-009 CMD_WDATA  input  8  write data.
REQ-010 RSP_VALID  output  1  one-cycle pulse: command complete.
REQ-011 RSP_RDATA  output  8  read data, valid while RSP_VALID is high.
REQ-012 BUS_ADDR  output  8  shared address bus.
REQ-013 BUS_DATA  inout  8  shared tristate data bus.
REQ-014 BUS_WE  output  1  bus write enable.
REQ-015 BUS_INTERRUPTS_RAISE  input  NUM_IRQ  peripheral interrupt requests.
REQ-016 BUS_INTERRUPTS_ACK  output  NUM_IRQ  interrupt acknowledge pulses.
REQ-017 IRQ_STATUS  output  NUM_IRQ  sticky record of serviced interrupts.
REQ-018 IRQ_CLR  input  NUM_IRQ  per-bit clear of IRQ_STATUS.

Function
REQ-019 FSM states: IDLE, WRITE, READ_ADDR, READ_WAIT, RESP.
REQ-020 IDLE: CMD_READY=1; handshake is CMD_VALID&CMD_READY on one edge; the command is latched and the FSM goes to WRITE or READ_ADDR.
REQ-021 CMD_READY is 0 in every state except IDLE.
REQ-022 WRITE (exactly 1 cycle): BUS_ADDR=addr, BUS_DATA driven with wdata, BUS_WE=1; then RESP.
REQ-023 READ_ADDR: BUS_ADDR=addr, BUS_WE=0, BUS_DATA=Z; a wait counter loads READ_LATENCY-1; then READ_WAIT.
REQ-024 READ_WAIT holds BUS_ADDR and decrements the counter; when the counter is 0, BUS_DATA is captured into RSP_RDATA; then RESP.
REQ-025 Read latency from handshake edge to RSP_VALID is READ_LATENCY+2 cycles; write latency is 2 cycles.
REQ-026 RESP: RSP_VALID=1 for exactly one cycle, then IDLE; RSP_RDATA holds its value until the next read completes.
REQ-027 BUS_DATA is driven only in WRITE; it is high-Z in all other states and during reset.
REQ-028 BUS_ADDR is 0xFF and BUS_WE is 0 in IDLE and RESP.
REQ-029 A CMD_VALID outside IDLE is ignored; no queueing.
REQ-030 Interrupt service: in any state, the lowest-index raised bit whose ACK was not asserted the previous cycle gets a 1-cycle ACK pulse.
REQ-031 At most one ACK bit is high per cycle; simultaneous raises are served lowest index first, on consecutive cycles.
REQ-032 Each ACK pulse sets the matching IRQ_STATUS bit.
REQ-033 IRQ_CLR on a bit in the same cycle as a new ACK on that bit leaves the bit set (set wins).

Reset
REQ-034 Asserting RESET (low) asynchronously forces: state IDLE, CMD_READY=0, RSP_VALID=0, RSP_RDATA=0x00, BUS_ADDR=0xFF, BUS_WE=0, BUS_DATA=Z, ACK=0, IRQ_STATUS=0, wait counter=0.
REQ-035 Reset during WRITE or READ aborts the command with no RSP_VALID.
REQ-036 CMD_READY rises on the first edge after RESET deasserts.

Configuration
REQ-037 Macro BUS_INITIATOR_IRQ_EN: when defined, REQ-030..033 are implemented.
REQ-038 Without BUS_INITIATOR_IRQ_EN: BUS_INTERRUPTS_ACK and IRQ_STATUS are tied to 0, IRQ_CLR and BUS_INTERRUPTS_RAISE are ignored, and no interrupt logic is synthesised.

Structure
REQ-039 Package bus_initiator_pkg holds the FSM state enum, the IDLE address constant 0xFF, and the bus width constants (8/8).
REQ-040 Sub-module bus_irq_arbiter holds the priority ACK and sticky status logic (REQ-030..033); it is instantiated only under BUS_INITIATOR_IRQ_EN.

Verification
REQ-041 Write 0xA5 to 0xC0 -> one cycle with BUS_ADDR=0xC0, BUS_DATA=0xA5, BUS_WE=1; RSP_VALID 2 cycles after the handshake.
REQ-042 Read 0x10 with a responder returning 0x3C at READ_LATENCY=2 -> RSP_RDATA=0x3C, RSP_VALID 4 cycles after the handshake, BUS_DATA never driven by the DUT.
REQ-043 Back-to-back CMD_VALID held high -> second handshake only after return to IDLE; the extra request is not double-executed.
REQ-044 RAISE=2'b11 same cycle -> ACK=01, then ACK=10 next cycle, IRQ_STATUS=11; IRQ_CLR=01 -> IRQ_STATUS=10.
REQ-045 RESET low mid-READ_WAIT -> all outputs at reset values immediately, no RSP_VALID, CMD_READY=1 one cycle after release.
REQ-046 Build without BUS_INITIATOR_IRQ_EN, RAISE=11 -> ACK stays 00, IRQ_STATUS stays 00.

Source files
------------

// File: rtl/bus_initiator_pkg.sv
// Shared types and constants for the bus initiator.
// Holds the FSM state encoding, the parked (idle) address value and bus widths.
package bus_initiator_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   // Address presented on the bus whenever no transfer is in flight
   localparam logic [ADDR_W-1:0] IDLE_ADDR = 8'hFF;

   // Wait counter must cover READ_LATENCY-1 for latencies up to 7
   localparam int CNT_W = 3;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WRITE     = 3'd1,
      READ_ADDR = 3'd2,
      READ_WAIT = 3'd3,
      RESP      = 3'd4
   } state_t;

endpackage

// File: rtl/bus_irq_arbiter.sv
// Fixed-priority interrupt acknowledger with sticky service status.
// Each cycle the lowest-index raised line that was not acknowledged in the
// previous cycle receives a one-cycle ACK; that ACK also sets its status bit.
// Only instantiated when BUS_INITIATOR_IRQ_EN is defined.
module bus_irq_arbiter #(
   parameter int NUM_IRQ = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] raise,
   input  logic [NUM_IRQ-1:0] clr,
   output logic [NUM_IRQ-1:0] ack,
   output logic [NUM_IRQ-1:0] status
);

   logic [NUM_IRQ-1:0] cand;
   logic [NUM_IRQ-1:0] grant;

   // A line just acknowledged is skipped once, so a peripheral that has not
   // yet dropped its request does not starve the higher indices.
   assign cand  = raise & ~ack;
   // Isolate the lowest set bit: at most one grant per cycle
   assign grant = cand & (~cand + NUM_IRQ'(1));

   // Register the grant as the ACK pulse; a new ACK overrides a same-cycle clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack    <= '0;
         status <= '0;
      end else begin
         ack    <= grant;
         status <= (status & ~clr) | grant;
      end
   end

endmodule

// File: rtl/bus_initiator.sv
// Single-outstanding command bus initiator with a shared tristate data bus.
// Host commands are accepted only in IDLE, executed as a one-cycle write or a
// READ_LATENCY-cycle read, and completed with a one-cycle RSP_VALID pulse.
// Optional interrupt acknowledge/status logic is built when the macro
// BUS_INITIATOR_IRQ_EN is defined; otherwise those outputs are tied to zero.
module bus_initiator
   import bus_initiator_pkg::*;
#(
   parameter int READ_LATENCY = 2,
   parameter int NUM_IRQ      = 2
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [ADDR_W-1:0] CMD_ADDR,
   input  logic [DATA_W-1:0] CMD_WDATA,
   output logic              RSP_VALID,
   output logic [DATA_W-1:0] RSP_RDATA,
   output logic [ADDR_W-1:0] BUS_ADDR,
   inout  wire  [DATA_W-1:0] BUS_DATA,
   output logic              BUS_WE,
   input  logic [NUM_IRQ-1:0] BUS_INTERRUPTS_RAISE,
   output logic [NUM_IRQ-1:0] BUS_INTERRUPTS_ACK,
   output logic [NUM_IRQ-1:0] IRQ_STATUS,
   input  logic [NUM_IRQ-1:0] IRQ_CLR
);

   state_t            state;
   logic [CNT_W-1:0]  wait_cnt;
   logic [DATA_W-1:0] wdata_q;
   logic              drive;
   logic              accept;

   assign accept = CMD_VALID & CMD_READY;

   // Data bus is driven only while the write cycle is on the bus
   assign BUS_DATA = drive ? wdata_q : {DATA_W{1'bz}};

   // Command FSM; every bus-facing output is registered alongside the state
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= IDLE;
         CMD_READY <= 1'b0;
         RSP_VALID <= 1'b0;
         RSP_RDATA <= '0;
         BUS_ADDR  <= IDLE_ADDR;
         BUS_WE    <= 1'b0;
         drive     <= 1'b0;
         wdata_q   <= '0;
         wait_cnt  <= '0;
      end else begin
         RSP_VALID <= 1'b0;
         case (state)
            IDLE: begin
               // CMD_READY stays low for the first cycle out of reset
               if (accept) begin
                  CMD_READY <= 1'b0;
                  BUS_ADDR  <= CMD_ADDR;
                  wdata_q   <= CMD_WDATA;
                  if (CMD_WRITE) begin
                     state  <= WRITE;
                     BUS_WE <= 1'b1;
                     drive  <= 1'b1;
                  end else begin
                     state  <= READ_ADDR;
                  end
               end else begin
                  CMD_READY <= 1'b1;
               end
            end
            WRITE: begin
               state     <= RESP;
               BUS_ADDR  <= IDLE_ADDR;
               BUS_WE    <= 1'b0;
               drive     <= 1'b0;
               RSP_VALID <= 1'b1;
            end
            READ_ADDR: begin
               state    <= READ_WAIT;
               wait_cnt <= CNT_W'(READ_LATENCY - 1);
            end
            READ_WAIT: begin
               if (wait_cnt == '0) begin
                  state     <= RESP;
                  RSP_RDATA <= BUS_DATA;
                  BUS_ADDR  <= IDLE_ADDR;
                  RSP_VALID <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP: begin
               state     <= IDLE;
               CMD_READY <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               CMD_READY <= 1'b0;
               BUS_ADDR  <= IDLE_ADDR;
               BUS_WE    <= 1'b0;
               drive     <= 1'b0;
            end
         endcase
      end
   end

`ifdef BUS_INITIATOR_IRQ_EN
   bus_irq_arbiter #(
      .NUM_IRQ (NUM_IRQ)
   ) u_irq (
      .clk    (CLK),
      .rst_n  (RESET),
      .raise  (BUS_INTERRUPTS_RAISE),
      .clr    (IRQ_CLR),
      .ack    (BUS_INTERRUPTS_ACK),
      .status (IRQ_STATUS)
   );
`else
   logic unused_irq;
   assign unused_irq         = ^{BUS_INTERRUPTS_RAISE, IRQ_CLR};
   assign BUS_INTERRUPTS_ACK = '0;
   assign IRQ_STATUS         = '0;
`endif

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed and randomized commands
// against a memory model, back-to-back requests, interrupt service and reset.
// Interrupt expectations follow whether BUS_INITIATOR_IRQ_EN is defined.
module tb_bus_initiator;

   localparam int LAT = 2;
   localparam int NI  = 2;
`ifdef BUS_INITIATOR_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          CMD_VALID = 1'b0;
   logic          CMD_READY;
   logic          CMD_WRITE = 1'b0;
   logic [7:0]    CMD_ADDR = 8'h00;
   logic [7:0]    CMD_WDATA = 8'h00;
   logic          RSP_VALID;
   logic [7:0]    RSP_RDATA;
   logic [7:0]    BUS_ADDR;
   wire  [7:0]    BUS_DATA;
   logic          BUS_WE;
   logic [NI-1:0] RAISE = '0;
   logic [NI-1:0] ACK;
   logic [NI-1:0] STATUS;
   logic [NI-1:0] CLR = '0;

   int checks = 0;
   int errors = 0;

   // Model of target memory as seen by the host: unwritten locations hold a^0x2C
   logic [7:0] mem_model [256];
   bit [255:0] mem_wr;

   // Bus peripheral: absorbs writes, answers reads whenever the DUT is not writing
   bit [7:0]   periph [256];
   bit [255:0] pw;
   logic       tb_en;
   logic [7:0] tb_drv;

   assign tb_en    = (BUS_WE !== 1'b1);
   assign tb_drv   = (BUS_ADDR == 8'hFF) ? 8'h00 :
                     (pw[BUS_ADDR] ? periph[BUS_ADDR] : (BUS_ADDR ^ 8'h2C));
   assign BUS_DATA = tb_en ? tb_drv : 8'hzz;

   always @(posedge CLK) begin
      if (BUS_WE === 1'b1) begin
         periph[BUS_ADDR] <= BUS_DATA;
         pw[BUS_ADDR]     <= 1'b1;
      end
   end

   always #5 CLK = ~CLK;

   bus_initiator #(.READ_LATENCY(LAT), .NUM_IRQ(NI)) dut (
      .CLK                  (CLK),
      .RESET                (RESET),
      .CMD_VALID            (CMD_VALID),
      .CMD_READY            (CMD_READY),
      .CMD_WRITE            (CMD_WRITE),
      .CMD_ADDR             (CMD_ADDR),
      .CMD_WDATA            (CMD_WDATA),
      .RSP_VALID            (RSP_VALID),
      .RSP_RDATA            (RSP_RDATA),
      .BUS_ADDR             (BUS_ADDR),
      .BUS_DATA             (BUS_DATA),
      .BUS_WE               (BUS_WE),
      .BUS_INTERRUPTS_RAISE (RAISE),
      .BUS_INTERRUPTS_ACK   (ACK),
      .IRQ_STATUS           (STATUS),
      .IRQ_CLR              (CLR)
   );

   function automatic logic [7:0] expect_mem(input logic [7:0] a);
      return mem_wr[a] ? mem_model[a] : (a ^ 8'h2C);
   endfunction

   // Runs one command from a falling edge; reports latency (cycles from the
   // handshake edge to the edge that samples RSP_VALID), read data, write
   // cycles seen, bus protocol violations and RSP_VALID one cycle later.
   task automatic do_cmd(input bit w, input logic [7:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd, output int we_cyc,
                         output int bad_bus, output logic rsp_after);
      int n;
      lat = 0; rd = 8'h00; we_cyc = 0; bad_bus = 0; rsp_after = 1'b1;
      n = 0;
      while (CMD_READY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      if (CMD_READY !== 1'b1) return;
      CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_WDATA = d;
      @(negedge CLK);
      CMD_VALID = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) @(negedge CLK);
         if (BUS_WE === 1'b1) begin
            we_cyc++;
            if (BUS_ADDR !== a || BUS_DATA !== d) bad_bus++;
         end else if (BUS_ADDR !== 8'hFF && BUS_ADDR !== a) begin
            bad_bus++;
         end
         if (RSP_VALID === 1'b1) begin
            lat = k; rd = RSP_RDATA;
            break;
         end
      end
      @(negedge CLK);
      rsp_after = RSP_VALID;
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", CMD_READY); end
      checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", RSP_VALID); end
      checks++; if (RSP_RDATA !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", RSP_RDATA); end
      checks++; if (BUS_ADDR !== 8'hFF) begin errors++; $display("FAIL reset_addr: got %h expected ff", BUS_ADDR); end
      checks++; if (BUS_WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", BUS_WE); end
      checks++; if (BUS_DATA !== 8'h00) begin errors++; $display("FAIL reset_bus_data_undriven: got %h expected 00", BUS_DATA); end
      checks++; if (ACK !== '0 || STATUS !== '0) begin errors++; $display("FAIL reset_irq: got ack %b status %b expected 0", ACK, STATUS); end
      RESET = 1'b1;
      #1;
      checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL release_ready_early: got %b expected 0", CMD_READY); end
      @(negedge CLK);
      checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", CMD_READY); end
   endtask

   task automatic test_irq();
      logic [NI-1:0] pend, prev, cand, exp_ack, exp_stat, clr;
      // two simultaneous requests, each held until its own acknowledge
      RAISE = 2'b11;
      @(negedge CLK);
      checks++; if (ACK !== (IRQ_EN ? 2'b01 : 2'b00)) begin errors++; $display("FAIL irq_ack_first: got %b expected %b", ACK, IRQ_EN ? 2'b01 : 2'b00); end
      RAISE = IRQ_EN ? 2'b10 : 2'b11;
      @(negedge CLK);
      checks++; if (ACK !== (IRQ_EN ? 2'b10 : 2'b00)) begin errors++; $display("FAIL irq_ack_second: got %b expected %b", ACK, IRQ_EN ? 2'b10 : 2'b00); end
      RAISE = 2'b00;
      @(negedge CLK);
      checks++; if (ACK !== 2'b00) begin errors++; $display("FAIL irq_ack_idle: got %b expected 00", ACK); end
      checks++; if (STATUS !== (IRQ_EN ? 2'b11 : 2'b00)) begin errors++; $display("FAIL irq_status_set: got %b expected %b", STATUS, IRQ_EN ? 2'b11 : 2'b00); end
      CLR = 2'b01;
      @(negedge CLK);
      CLR = 2'b00;
      checks++; if (STATUS !== (IRQ_EN ? 2'b10 : 2'b00)) begin errors++; $display("FAIL irq_status_clr: got %b expected %b", STATUS, IRQ_EN ? 2'b10 : 2'b00); end
      // random requests held until acknowledged, random clears
      pend = '0; prev = '0; exp_stat = IRQ_EN ? 2'b10 : 2'b00;
      for (int i = 0; i < 40; i++) begin
         clr   = NI'($urandom_range(0, 7) == 0 ? $urandom : 0);
         RAISE = pend; CLR = clr;
         @(negedge CLK);
         exp_ack = '0;
         if (IRQ_EN) begin
            cand = pend & ~prev;
            for (int b = 0; b < NI; b++) if (cand[b]) begin exp_ack[b] = 1'b1; break; end
            exp_stat = (exp_stat & ~clr) | exp_ack;
         end
         checks++; if (ACK !== exp_ack) begin errors++; $display("FAIL irq_rand_ack[%0d]: got %b expected %b", i, ACK, exp_ack); end
         checks++; if (STATUS !== exp_stat) begin errors++; $display("FAIL irq_rand_status[%0d]: got %b expected %b", i, STATUS, exp_stat); end
         pend = (pend & ~exp_ack) | NI'($urandom_range(0, 1) == 0 ? $urandom : 0);
         prev = exp_ack;
      end
      RAISE = '0; CLR = '1;
      repeat (2) @(negedge CLK);
      CLR = '0;
   endtask

   task automatic test_write();
      int lat, we_cyc, bad; logic [7:0] rd; logic ra;
      do_cmd(1'b1, 8'hC0, 8'hA5, lat, rd, we_cyc, bad, ra);
      mem_model[8'hC0] = 8'hA5; mem_wr[8'hC0] = 1'b1;
      checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency: got %0d expected 2", lat); end
      checks++; if (we_cyc !== 1) begin errors++; $display("FAIL write_we_cycles: got %0d expected 1", we_cyc); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL write_bus: got %0d bad cycles expected 0", bad); end
      checks++; if (ra !== 1'b0) begin errors++; $display("FAIL write_rsp_pulse: got %b expected 0", ra); end
   endtask

   task automatic test_read();
      int lat, we_cyc, bad; logic [7:0] rd; logic ra;
      do_cmd(1'b0, 8'h10, 8'h00, lat, rd, we_cyc, bad, ra);
      checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL read_data: got %h expected 3c", rd); end
      checks++; if (lat !== LAT + 2) begin errors++; $display("FAIL read_latency: got %0d expected %0d", lat, LAT + 2); end
      checks++; if (we_cyc !== 0 || bad !== 0) begin errors++; $display("FAIL read_bus: got we %0d bad %0d expected 0 0", we_cyc, bad); end
      checks++; if (ra !== 1'b0) begin errors++; $display("FAIL read_rsp_pulse: got %b expected 0", ra); end
      checks++; if (RSP_RDATA !== 8'h3C) begin errors++; $display("FAIL read_data_hold: got %h expected 3c", RSP_RDATA); end
   endtask

   task automatic test_random();
      int lat, we_cyc, bad; logic [7:0] rd, a, d, last_rd; logic ra; bit w;
      last_rd = RSP_RDATA;
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom);
         a = 8'($urandom_range(0, 15) | (($urandom_range(0, 1) == 0) ? 8'hC0 : 8'h00));
         d = 8'($urandom);
         do_cmd(w, a, d, lat, rd, we_cyc, bad, ra);
         checks++; if (lat !== (w ? 2 : LAT + 2)) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, w ? 2 : LAT + 2); end
         checks++; if (we_cyc !== (w ? 1 : 0) || bad !== 0) begin errors++; $display("FAIL rand_bus[%0d]: got we %0d bad %0d expected %0d 0", i, we_cyc, bad, w ? 1 : 0); end
         if (w) begin
            mem_model[a] = d; mem_wr[a] = 1'b1;
            checks++; if (rd !== last_rd) begin errors++; $display("FAIL rand_rdata_hold[%0d]: got %h expected %h", i, rd, last_rd); end
         end else begin
            last_rd = expect_mem(a);
            checks++; if (rd !== last_rd) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, rd, last_rd); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int hs, we, rsp, n;
      hs = 0; we = 0; rsp = 0; n = 0;
      while (CMD_READY !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
      CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 8'h40; CMD_WDATA = 8'h77;
      // a write takes three cycles round trip, so six cycles of a held request
      // yield exactly two accepted commands
      for (int k = 0; k < 6; k++) begin
         if (CMD_READY === 1'b1) hs++;
         if (BUS_WE === 1'b1) we++;
         if (RSP_VALID === 1'b1) rsp++;
         @(negedge CLK);
      end
      CMD_VALID = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (BUS_WE === 1'b1) we++;
         if (RSP_VALID === 1'b1) rsp++;
         @(negedge CLK);
      end
      mem_model[8'h40] = 8'h77; mem_wr[8'h40] = 1'b1;
      checks++; if (hs !== 2) begin errors++; $display("FAIL b2b_handshakes: got %0d expected 2", hs); end
      checks++; if (we !== 2) begin errors++; $display("FAIL b2b_write_cycles: got %0d expected 2", we); end
      checks++; if (rsp !== 2) begin errors++; $display("FAIL b2b_responses: got %0d expected 2", rsp); end
   endtask

   task automatic test_reset_mid_read();
      int rsp, lat, we_cyc, bad; logic [7:0] rd; logic ra;
      rsp = 0;
      CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 8'h20;
      @(negedge CLK);
      CMD_VALID = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      checks++; if (RSP_RDATA !== 8'h00 || RSP_VALID !== 1'b0) begin errors++; $display("FAIL midread_rsp: got valid %b data %h expected 0 00", RSP_VALID, RSP_RDATA); end
      checks++; if (BUS_ADDR !== 8'hFF || BUS_WE !== 1'b0 || CMD_READY !== 1'b0) begin errors++; $display("FAIL midread_bus: got addr %h we %b ready %b expected ff 0 0", BUS_ADDR, BUS_WE, CMD_READY); end
      checks++; if (ACK !== '0 || STATUS !== '0) begin errors++; $display("FAIL midread_irq: got ack %b status %b expected 0", ACK, STATUS); end
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         if (RSP_VALID === 1'b1) rsp++;
      end
      RESET = 1'b1;
      #1;
      checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL midread_ready_early: got %b expected 0", CMD_READY); end
      @(negedge CLK);
      if (RSP_VALID === 1'b1) rsp++;
      checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL midread_ready: got %b expected 1", CMD_READY); end
      checks++; if (rsp !== 0) begin errors++; $display("FAIL midread_no_rsp: got %0d pulses expected 0", rsp); end
      do_cmd(1'b0, 8'hC0, 8'h00, lat, rd, we_cyc, bad, ra);
      checks++; if (rd !== expect_mem(8'hC0) || lat !== LAT + 2) begin errors++; $display("FAIL postreset_read: got %h lat %0d expected %h lat %0d", rd, lat, expect_mem(8'hC0), LAT + 2); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_irq();
      test_write();
      test_read();
      test_random();
      test_back_to_back();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
